// File: rtl/spi_flash_reader_if.sv
// Byte-read request/status bus between the SpiFlash RAM core (master) and the
// flash reader (slave).
interface spi_flash_reader_if;
  logic [23:0] addr;
  logic        rden;
  logic        read;
  logic        busy;
  logic        data_valid;
  logic [7:0]  dataout;

  modport master (output addr, rden, read, input busy, data_valid, dataout);
  modport slave  (input addr, rden, read, output busy, data_valid, dataout);
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) byte engine; keeps CS low across consecutive addresses
// so sequential fetches only clock the 8 data bits.
//
// state   | meaning
// S_IDLE  | cs_n high, gap satisfied, waiting for a request
// S_CSGAP | cs_n forced high for CS_HIGH cycles (pend_q: a fresh command follows)
// S_CMD   | shifting 0x03 + 24-bit address out on MOSI
// S_DATA  | sampling 8 bits from MISO, then SCK back low
// S_HOLD  | cs_n held low waiting HOLD_CYC cycles for a sequential request
module spi_flash_reader #(
  parameter int CLK_DIV  = 2,
  parameter int HOLD_CYC = 64,
  parameter int CS_HIGH  = 2
) (
  input  logic              clkin,
  input  logic              reset_n,
  spi_flash_reader_if.slave bus,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DW = (CLK_DIV > 1)  ? $clog2(CLK_DIV)  : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int GW = (CS_HIGH > 1)  ? $clog2(CS_HIGH)  : 1;
  localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(CS_HIGH - 1);
  localparam logic [7:0]    CMD_READ  = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CSGAP, S_CMD, S_DATA, S_HOLD} state_t;

  state_t       state_q, state_d;
  logic [DW-1:0] div_q, div_d, div_eff;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [31:0]  cmd_sr_q, cmd_sr_d;
  logic [7:0]   rx_sr_q, rx_sr_d;
  logic [23:0]  addr_q, addr_d, cmd_addr;
  logic         last_vld_q, last_vld_d;
  logic         pend_q, pend_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         data_valid_q, data_valid_d;
  logic [7:0]   dataout_q, dataout_d;
  logic         sck_q, sck_d;
  logic         cs_n_q, cs_n_d;
  logic         mosi_q, mosi_d;
  logic         accept, seq_hit, start_cmd, run;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      hold_q       <= '0;
      gap_q        <= '0;
      cnt_q        <= '0;
      cmd_sr_q     <= '0;
      rx_sr_q      <= '0;
      addr_q       <= '0;
      last_vld_q   <= 1'b0;
      pend_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      dataout_q    <= '0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      cnt_q        <= cnt_d;
      cmd_sr_q     <= cmd_sr_d;
      rx_sr_q      <= rx_sr_d;
      addr_q       <= addr_d;
      last_vld_q   <= last_vld_d;
      pend_q       <= pend_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      dataout_q    <= dataout_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    cnt_d        = cnt_q;
    cmd_sr_d     = cmd_sr_q;
    rx_sr_d      = rx_sr_q;
    addr_d       = addr_q;
    last_vld_d   = last_vld_q;
    pend_d       = pend_q;
    done_d       = done_q;
    busy_d       = busy_q;
    data_valid_d = 1'b0;
    dataout_d    = dataout_q;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    start_cmd    = 1'b0;
    run          = 1'b0;
    div_eff      = div_q;
    cmd_addr     = addr_q;

    accept  = bus.read && bus.rden && !busy_q &&
              ((state_q == S_IDLE) || (state_q == S_HOLD));
    // The expiry cycle itself never counts as sequential.
    seq_hit = (state_q == S_HOLD) && last_vld_q && (hold_q != '0) &&
              (bus.addr == addr_q + 24'd1);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = bus.addr;
          busy_d    = 1'b1;
          cmd_addr  = bus.addr;
          start_cmd = 1'b1;
        end
      end
      S_CSGAP: begin
        if (gap_q == '0) begin
          if (pend_q) begin
            start_cmd = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_CMD, S_DATA: run = 1'b1;
      S_HOLD: begin
        if (accept && seq_hit) begin
          // The accept cycle already counts as the first SCK-low cycle.
          addr_d  = bus.addr;
          busy_d  = 1'b1;
          state_d = S_DATA;
          div_eff = DIV_LOAD;
          run     = 1'b1;
        end else if (accept || (hold_q == '0)) begin
          if (accept) addr_d = bus.addr;
          pend_d  = accept;
          state_d = S_CSGAP;
          cs_n_d  = 1'b1;
          busy_d  = 1'b1;
          gap_d   = GAP_LOAD;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_cmd) begin
      state_d  = S_CMD;
      cs_n_d   = 1'b0;
      div_d    = DIV_LOAD;
      cnt_d    = '0;
      mosi_d   = CMD_READ[7];
      cmd_sr_d = {CMD_READ[6:0], cmd_addr, 1'b0};
    end

    if (run) begin
      if (div_eff != '0) begin
        div_d = div_eff - DW'(1);
      end else begin
        div_d = DIV_LOAD;
        if (!sck_q) begin
          sck_d = 1'b1;
          cnt_d = cnt_q + 6'd1;
          if (state_q == S_CMD) begin
            if (cnt_q == 6'd31) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end
          end else begin
            rx_sr_d = {rx_sr_q[6:0], spi_miso};
            if (cnt_q == 6'd7) done_d = 1'b1;
          end
        end else begin
          sck_d = 1'b0;
          if (state_q == S_CMD) begin
            mosi_d   = cmd_sr_q[31];
            cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
          end else begin
            mosi_d = 1'b0;
            if (cnt_q == 6'd8) begin
              state_d = S_HOLD;
              cnt_d   = '0;
              hold_d  = HOLD_LOAD;
            end
          end
        end
      end
    end

    if (done_q) begin
      done_d       = 1'b0;
      data_valid_d = 1'b1;
      dataout_d    = rx_sr_q;
      busy_d       = 1'b0;
      last_vld_d   = 1'b1;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.data_valid = data_valid_q;
  assign bus.dataout    = dataout_q;
  assign spi_sck        = sck_q;
  assign spi_cs_n       = cs_n_q;
  assign spi_mosi       = mosi_q;

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Byte-read engine for the serial configuration/boot flash; consumes the byte-read requests issued by the Wishbone SpiFlash RAM core.
- Provides the same request/status interface the core drives: addr, rden, read, busy, data_valid, dataout.
- Generates SPI mode-0 READ (0x03) transactions on the flash pins.
- Keeps CS asserted between requests to consecutive addresses, so sequential BIOS/ROM fetches skip the 32-bit command/address phase.

Parameters:
- CLK_DIV, 2, SCK half-period in clkin cycles (>=1); SCK period = 2*CLK_DIV.
- HOLD_CYC, 64, clkin cycles CS stays low waiting for a sequential request before release.
- CS_HIGH, 2, minimum clkin cycles cs_n stays high between transactions (tSHSL).

Ports:
- clkin  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- addr  input  24  flash byte address; sampled at request acceptance.
- rden  input  1  read enable; qualifies read.
- read  input  1  request strobe; accepted when read & rden & !busy.
- busy  output  1  transaction in progress; requests ignored while high.
- data_valid  output  1  one-cycle pulse; dataout valid.
- dataout  output  8  last byte read; holds until the next data_valid.
- spi_sck  output  1  flash clock; idles low.
- spi_cs_n  output  1  flash chip select, active low.
- spi_mosi  output  1  serial data to flash, MSB first.
- spi_miso  input  1  serial data from flash; sampled on SCK rising edge.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: busy=0, data_valid=0, dataout=0, spi_sck=0, spi_cs_n=1, spi_mosi=0.
  - State: IDLE; sequential-address register cleared and marked invalid.
  - Mid-transfer reset aborts immediately; CS rises in the same instant.
- States: IDLE, CSGAP, CMD (32 bits: 0x03 + addr[23:0]), DATA (8 bits), HOLD.
- Accept cycle = cycle 0 (read & rden & !busy in IDLE or HOLD):
  - Latch addr.
  - busy rises at cycle 1 and stays high until the data_valid cycle.
- Fresh path (IDLE, or HOLD with non-sequential addr):
  - From HOLD: raise cs_n and go through CSGAP for CS_HIGH cycles first.
  - From IDLE with the CS_HIGH gap already elapsed: cs_n falls at cycle 1.
  - MOSI is set up before each rising edge and changes only while SCK is low.
  - Rising edge n (1-based) occurs at cycle 1+(2n-1)*CLK_DIV.
  - Bits 1..32 are command and address; bits 33..40 sample MISO.
- Sequential path (HOLD and addr == last_addr+1 mod 2^24, so 0xFFFFFF -> 0x000000 is sequential):
  - CS stays low; skip CMD.
  - 8 data edges at cycle (2n-1)*CLK_DIV, n=1..8.
- Completion:
  - data_valid=1 and dataout updated in the cycle after the last rising edge; busy falls in that same cycle.
  - SCK returns low CLK_DIV cycles after the last rising edge; enter HOLD.
  - Fresh latency (IDLE start) = 2+79*CLK_DIV cycles; sequential latency = 1+15*CLK_DIV cycles.
- HOLD:
  - Counts HOLD_CYC cycles. On expiry, cs_n=1 and go to CSGAP, then IDLE after CS_HIGH cycles.
  - A request arriving on the expiry cycle is treated as non-sequential.
- Request ignored (no latch, no effect) when:
  - read=1 with rden=0;
  - read while busy;
  - read during CSGAP (busy=1 during CSGAP).
- Output stability:
  - dataout never changes except on a data_valid cycle.
  - spi_mosi is don't-care during DATA but driven 0.

Test Plan:
- Reset then fresh read, CLK_DIV=2, addr=0x012345, flash model returns 0xA5:
  - MOSI carries 0x03,0x01,0x23,0x45.
  - 40 SCK pulses; data_valid at cycle 160; dataout=0xA5; busy low at cycle 160.
- Sequential read addr=0x012346 issued 5 cycles after the previous data_valid:
  - No CS rise; 8 SCK pulses only; data_valid 31 cycles after accept.
- Non-sequential read addr=0x000000 during HOLD:
  - cs_n high for 2 cycles, then full 40-bit transaction with address 0x000000.
- Wrap: read 0xFFFFFF, then 0x000000 within HOLD:
  - Second read uses the sequential path (8 SCK pulses).
- No read for 64 cycles after data_valid:
  - cs_n rises at the timeout; the next read at 0x000001 is fresh (40 pulses).
- Assert reset_n=0 at bit 20 of CMD:
  - cs_n=1, sck=0, busy=0 asynchronously; no data_valid.
- Assert read with rden=0, and read while busy:
  - Both ignored; no extra transaction; dataout unchanged.
